// File: rtl/spmm_row_sched.sv
// spmm_row_sched: row sequencer for the sparse x dense multiply datapath.
// Takes row-sorted COO nonzeros, fetches the matching dense rows and walks the
// partial-sum buffer one beat per cycle. Each finished row is drained as
// out_valid beats. Each empty row is reported as a single zeros pulse.
// Optional build macro SPMM_PERF_CNT_EN adds the perf_cycles_o/perf_stalls_o
// counters.
//
// state   | meaning
// IDLE    | waiting for start
// GET     | accepting one COO entry
// ISSUE   | one-cycle dense row fetch request
// COMPUTE | NB beats through the multiply/accumulate pipe
// WAIT    | PIPE_LAT cycles so the last accumulate write lands
// FLUSH   | NB buffer reads (+RD_LAT drain) emitted as out_valid beats
// ZFILL   | zeros pulses for empty rows up to the next target row
// DONE    | one-cycle done pulse
module spmm_row_sched #(
  parameter int ROW_W    = 10,
  parameter int NB       = 280,
  parameter int OUT_ROWS = 560,
  parameter int PIPE_LAT = 4,
  parameter int RD_LAT   = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             ent_valid_i,
  output logic             ent_ready_o,
  input  logic [ROW_W-1:0] ent_row_i,
  input  logic [ROW_W-1:0] ent_col_i,
  input  logic             ent_last_i,
  output logic             dense_req_o,
  output logic [ROW_W-1:0] dense_addr_o,
  output logic             beat_en_o,
  output logic [8:0]       buf_raddr_o,
  output logic             acc_bypass_o,
  output logic             buf_we_o,
  output logic [8:0]       buf_waddr_o,
  output logic             out_valid_o,
  output logic [ROW_W-1:0] out_row_o,
  output logic             zeros_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             order_err_o
`ifdef SPMM_PERF_CNT_EN
  ,
  output logic [31:0]      perf_cycles_o,
  output logic [31:0]      perf_stalls_o
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_GET, S_ISSUE, S_COMPUTE, S_WAIT, S_FLUSH, S_ZFILL, S_DONE
  } state_e;

  localparam int AW = 9;
  localparam logic [AW-1:0]  B_LAST   = AW'(NB - 1);
  localparam logic [AW-1:0]  W_LAST   = AW'(PIPE_LAT - 1);
  localparam logic [AW-1:0]  F_LAST   = AW'(NB + RD_LAT - 1);
  localparam logic [AW-1:0]  NB_A     = AW'(NB);
  localparam logic [ROW_W:0] ROWS_END = (ROW_W + 1)'(OUT_ROWS);

  state_e           state_q;
  logic [AW-1:0]    beat_q;
  logic [ROW_W-1:0] cur_row_q;
  logic             row_act_q;
  logic             first_q;
  logic [ROW_W-1:0] pend_row_q;
  logic [ROW_W-1:0] pend_col_q;
  logic             pend_last_q;
  logic             last_seen_q;
  logic [ROW_W:0]   next_out_q;
  logic [ROW_W-1:0] dense_addr_q;
  logic             order_err_q;

  logic             we_pipe_q    [PIPE_LAT];
  logic             byp_pipe_q   [PIPE_LAT];
  logic [AW-1:0]    waddr_pipe_q [PIPE_LAT];
  logic             rd_pipe_q    [RD_LAT];

  logic             rd_iss;
  logic             zf_more;
  logic [ROW_W:0]   zf_target;

  // After the final entry the fill runs to the end of the matrix.
  assign zf_target = last_seen_q ? ROWS_END : {1'b0, pend_row_q};
  assign zf_more   = next_out_q < zf_target;
  assign rd_iss    = (state_q == S_FLUSH) && (beat_q < NB_A);

  assign ent_ready_o  = (state_q == S_GET);
  assign dense_req_o  = (state_q == S_ISSUE);
  assign dense_addr_o = (state_q == S_ISSUE) ? pend_col_q : dense_addr_q;
  assign beat_en_o    = (state_q == S_COMPUTE);
  assign buf_raddr_o  = (beat_en_o || rd_iss) ? beat_q : '0;
  assign buf_we_o     = we_pipe_q[PIPE_LAT-1];
  assign buf_waddr_o  = waddr_pipe_q[PIPE_LAT-1];
  assign acc_bypass_o = byp_pipe_q[PIPE_LAT-1];
  assign out_valid_o  = rd_pipe_q[RD_LAT-1];
  assign zeros_o      = (state_q == S_ZFILL) && zf_more;
  assign out_row_o    = zeros_o ? next_out_q[ROW_W-1:0] :
                        (out_valid_o ? cur_row_q : '0);
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = (state_q == S_DONE);
  assign order_err_o  = order_err_q;

  // Main sequencer: entry intake, beat/flush counting, row bookkeeping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      beat_q       <= '0;
      cur_row_q    <= '0;
      row_act_q    <= 1'b0;
      first_q      <= 1'b1;
      pend_row_q   <= '0;
      pend_col_q   <= '0;
      pend_last_q  <= 1'b0;
      last_seen_q  <= 1'b0;
      next_out_q   <= '0;
      dense_addr_q <= '0;
      order_err_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q     <= S_GET;
            next_out_q  <= '0;
            row_act_q   <= 1'b0;
            first_q     <= 1'b1;
            last_seen_q <= 1'b0;
            order_err_q <= 1'b0;
          end
        end
        S_GET: begin
          if (ent_valid_i) begin
            if (row_act_q && (ent_row_i < cur_row_q)) begin
              // Out-of-order entry is dropped; a dropped last still ends the pass.
              order_err_q <= 1'b1;
              if (ent_last_i) begin
                last_seen_q <= 1'b1;
                beat_q      <= '0;
                state_q     <= S_WAIT;
              end
            end else begin
              pend_row_q  <= ent_row_i;
              pend_col_q  <= ent_col_i;
              pend_last_q <= ent_last_i;
              if (!row_act_q) begin
                state_q <= S_ZFILL;
              end else if (ent_row_i == cur_row_q) begin
                state_q <= S_ISSUE;
              end else begin
                beat_q  <= '0;
                state_q <= S_WAIT;
              end
            end
          end
        end
        S_ISSUE: begin
          dense_addr_q <= pend_col_q;
          beat_q       <= '0;
          state_q      <= S_COMPUTE;
        end
        S_COMPUTE: begin
          if (beat_q == B_LAST) begin
            beat_q  <= '0;
            first_q <= 1'b0;
            if (pend_last_q) begin
              last_seen_q <= 1'b1;
              state_q     <= S_WAIT;
            end else begin
              state_q <= S_GET;
            end
          end else begin
            beat_q <= beat_q + 1'b1;
          end
        end
        S_WAIT: begin
          if (beat_q == W_LAST) begin
            beat_q  <= '0;
            state_q <= S_FLUSH;
          end else begin
            beat_q <= beat_q + 1'b1;
          end
        end
        S_FLUSH: begin
          // Runs RD_LAT extra cycles so the last beat drains before any zeros pulse.
          if (beat_q == F_LAST) begin
            beat_q     <= '0;
            next_out_q <= {1'b0, cur_row_q} + 1'b1;
            state_q    <= S_ZFILL;
          end else begin
            beat_q <= beat_q + 1'b1;
          end
        end
        S_ZFILL: begin
          if (zf_more) begin
            next_out_q <= next_out_q + 1'b1;
          end else if (last_seen_q) begin
            state_q <= S_DONE;
          end else begin
            cur_row_q <= pend_row_q;
            row_act_q <= 1'b1;
            first_q   <= 1'b1;
            state_q   <= S_ISSUE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Delay issue-time write controls by PIPE_LAT to line up with the datapath.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        we_pipe_q[i]    <= 1'b0;
        byp_pipe_q[i]   <= 1'b0;
        waddr_pipe_q[i] <= '0;
      end
    end else begin
      we_pipe_q[0]    <= beat_en_o;
      byp_pipe_q[0]   <= beat_en_o & first_q;
      waddr_pipe_q[0] <= beat_en_o ? beat_q : '0;
      for (int i = 1; i < PIPE_LAT; i++) begin
        we_pipe_q[i]    <= we_pipe_q[i-1];
        byp_pipe_q[i]   <= byp_pipe_q[i-1];
        waddr_pipe_q[i] <= waddr_pipe_q[i-1];
      end
    end
  end

  // Flush reads become out_valid once the buffer read latency has elapsed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < RD_LAT; i++) rd_pipe_q[i] <= 1'b0;
    end else begin
      rd_pipe_q[0] <= rd_iss;
      for (int i = 1; i < RD_LAT; i++) rd_pipe_q[i] <= rd_pipe_q[i-1];
    end
  end

`ifdef SPMM_PERF_CNT_EN
  logic [31:0] perf_cycles_q;
  logic [31:0] perf_stalls_q;

  assign perf_cycles_o = perf_cycles_q;
  assign perf_stalls_o = perf_stalls_q;

  // Busy-cycle and starved-GET counters, cleared by start, frozen while idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else if (state_q == S_IDLE) begin
      if (start_i) begin
        perf_cycles_q <= '0;
        perf_stalls_q <= '0;
      end
    end else begin
      perf_cycles_q <= perf_cycles_q + 32'd1;
      if ((state_q == S_GET) && !ent_valid_i) perf_stalls_q <= perf_stalls_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_spmm_row_sched.sv
// Self-checking bench for spmm_row_sched (NB=4, PIPE_LAT=2, OUT_ROWS=4, RD_LAT=1).
// A row-level model fills scoreboards of output events, fetch addresses and
// bypass values. A negedge monitor pops and compares them.
module tb_spmm_row_sched;
  localparam int ROW_W = 10, NB = 4, OUT_ROWS = 4, PIPE_LAT = 2, RD_LAT = 1;

  logic clk_i = 1'b0, rst_ni = 1'b0, start_i = 1'b0, ent_valid_i = 1'b0, ent_last_i = 1'b0;
  logic [ROW_W-1:0] ent_row_i = '0, ent_col_i = '0;
  logic ent_ready_o, dense_req_o, beat_en_o, acc_bypass_o, buf_we_o;
  logic out_valid_o, zeros_o, busy_o, done_o, order_err_o;
  logic [ROW_W-1:0] dense_addr_o, out_row_o;
  logic [8:0] buf_raddr_o, buf_waddr_o;
`ifdef SPMM_PERF_CNT_EN
  logic [31:0] perf_cycles_o, perf_stalls_o;
`endif

  spmm_row_sched #(.ROW_W(ROW_W), .NB(NB), .OUT_ROWS(OUT_ROWS),
                   .PIPE_LAT(PIPE_LAT), .RD_LAT(RD_LAT)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
    .ent_valid_i(ent_valid_i), .ent_ready_o(ent_ready_o),
    .ent_row_i(ent_row_i), .ent_col_i(ent_col_i), .ent_last_i(ent_last_i),
    .dense_req_o(dense_req_o), .dense_addr_o(dense_addr_o),
    .beat_en_o(beat_en_o), .buf_raddr_o(buf_raddr_o),
    .acc_bypass_o(acc_bypass_o), .buf_we_o(buf_we_o), .buf_waddr_o(buf_waddr_o),
    .out_valid_o(out_valid_o), .out_row_o(out_row_o), .zeros_o(zeros_o),
    .busy_o(busy_o), .done_o(done_o), .order_err_o(order_err_o)
`ifdef SPMM_PERF_CNT_EN
    , .perf_cycles_o(perf_cycles_o), .perf_stalls_o(perf_stalls_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_err = 0;

  int exp_out[$];   // 1024 + row for a valid beat, 2048 + row for a zeros pulse
  int exp_addr[$];
  int exp_byp[$];
  int e_row[$];
  int e_col[$];
  int e_last[$];

  bit mon_en = 1'b0;
  bit done_seen = 1'b0;
  logic be_h1 = 1'b0, be_h2 = 1'b0;
  logic [8:0] ra_h1 = '0, ra_h2 = '0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic check_quiet(input string pfx);
    check_eq({pfx, "_busy"},   int'(busy_o), 0);
    check_eq({pfx, "_ready"},  int'(ent_ready_o), 0);
    check_eq({pfx, "_dreq"},   int'(dense_req_o), 0);
    check_eq({pfx, "_daddr"},  int'(dense_addr_o), 0);
    check_eq({pfx, "_beat"},   int'(beat_en_o), 0);
    check_eq({pfx, "_raddr"},  int'(buf_raddr_o), 0);
    check_eq({pfx, "_we"},     int'(buf_we_o), 0);
    check_eq({pfx, "_waddr"},  int'(buf_waddr_o), 0);
    check_eq({pfx, "_byp"},    int'(acc_bypass_o), 0);
    check_eq({pfx, "_ovalid"}, int'(out_valid_o), 0);
    check_eq({pfx, "_orow"},   int'(out_row_o), 0);
    check_eq({pfx, "_zeros"},  int'(zeros_o), 0);
    check_eq({pfx, "_done"},   int'(done_o), 0);
    check_eq({pfx, "_oerr"},   int'(order_err_o), 0);
  endtask

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk_i) begin
    int ev;
    if (mon_en) begin
      if (out_valid_o || zeros_o) begin
        ev = (out_valid_o ? 1024 : 0) + (zeros_o ? 2048 : 0) + int'(out_row_o);
        if (exp_out.size() == 0) check_eq("out_unexp", ev, -1);
        else check_eq("out_evt", ev, exp_out.pop_front());
      end
      if (dense_req_o) begin
        if (exp_addr.size() == 0) check_eq("daddr_unexp", int'(dense_addr_o), -1);
        else check_eq("daddr", int'(dense_addr_o), exp_addr.pop_front());
      end
      if (buf_we_o || be_h2) begin
        check_eq("we_align", int'(buf_we_o), int'(be_h2));
        if (buf_we_o) begin
          check_eq("waddr_align", int'(buf_waddr_o), int'(ra_h2));
          if (exp_byp.size() == 0) check_eq("byp_unexp", int'(acc_bypass_o), -1);
          else check_eq("bypass", int'(acc_bypass_o), exp_byp.pop_front());
        end
      end
      if (done_o) done_seen = 1'b1;
    end
    be_h2 = be_h1;
    be_h1 = beat_en_o;
    ra_h2 = ra_h1;
    ra_h1 = buf_raddr_o;
  end

  task automatic add_ent(input int r, input int c, input int l);
    e_row.push_back(r);
    e_col.push_back(c);
    e_last.push_back(l);
  endtask

  // Row-level reference: which rows are filled, which are empty, what is fetched.
  task automatic build_expect();
    int cur;
    int nxt;
    int first;
    cur = -1;
    nxt = 0;
    first = 0;
    for (int i = 0; i < e_row.size(); i++) begin
      if (cur >= 0 && e_row[i] < cur) continue;
      if (e_row[i] != cur) begin
        if (cur >= 0) begin
          for (int b = 0; b < NB; b++) exp_out.push_back(1024 + cur);
          nxt = cur + 1;
        end
        for (int r = nxt; r < e_row[i]; r++) exp_out.push_back(2048 + r);
        cur = e_row[i];
        first = 1;
      end
      exp_addr.push_back(e_col[i]);
      for (int b = 0; b < NB; b++) exp_byp.push_back(first);
      first = 0;
    end
    if (cur >= 0) begin
      for (int b = 0; b < NB; b++) exp_out.push_back(1024 + cur);
      nxt = cur + 1;
    end
    for (int r = nxt; r < OUT_ROWS; r++) exp_out.push_back(2048 + r);
  endtask

  task automatic pulse_start();
    @(posedge clk_i); #1;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic feed_one(input int i, input int gap);
    bit hs;
    if (i > 0 && gap > 0) begin
      hs = 1'b0;
      for (int t = 0; t < 200 && !hs; t++) begin
        @(negedge clk_i);
        hs = ent_ready_o;
        if (!hs) begin @(posedge clk_i); #1; end
      end
      repeat (gap) @(posedge clk_i);
      #1;
    end
    ent_row_i   = ROW_W'(e_row[i]);
    ent_col_i   = ROW_W'(e_col[i]);
    ent_last_i  = e_last[i][0];
    ent_valid_i = 1'b1;
    hs = 1'b0;
    for (int t = 0; t < 200 && !hs; t++) begin
      @(negedge clk_i);
      hs = ent_ready_o;
      @(posedge clk_i); #1;
    end
    check_eq("handshake", int'(hs), 1);
    ent_valid_i = 1'b0;
    ent_last_i  = 1'b0;
  endtask

  task automatic run_pass(input int gap, input int want_err);
    build_expect();
    done_seen = 1'b0;
    pulse_start();
    for (int i = 0; i < e_row.size(); i++) feed_one(i, gap);
    for (int t = 0; t < 400 && !done_seen; t++) @(posedge clk_i);
    check_eq("done", int'(done_seen), 1);
    repeat (2) @(posedge clk_i);
    #1;
    check_eq("idle_busy", int'(busy_o), 0);
    check_eq("out_left", exp_out.size(), 0);
    check_eq("addr_left", exp_addr.size(), 0);
    check_eq("byp_left", exp_byp.size(), 0);
    check_eq("order_err", int'(order_err_o), want_err);
    e_row.delete(); e_col.delete(); e_last.delete();
    exp_out.delete(); exp_addr.delete(); exp_byp.delete();
  endtask

  initial begin
    bit found;
    repeat (3) @(posedge clk_i);
    #1;
    check_quiet("reset");
    rst_ni = 1'b1;
    mon_en = 1'b1;

    add_ent(1, 2, 0); add_ent(1, 3, 1);
    run_pass(0, 0);

    add_ent(3, 0, 1);
    run_pass(0, 0);

    add_ent(0, 1, 0); add_ent(2, 1, 1);
    run_pass(5, 0);
`ifdef SPMM_PERF_CNT_EN
    check_eq("perf_stalls_ge5", int'(perf_stalls_o >= 32'd5), 1);
    check_eq("perf_cycles_nz", int'(perf_cycles_o != 32'd0), 1);
`endif

    add_ent(2, 0, 0); add_ent(1, 0, 1);
    run_pass(0, 1);

    // Abort a pass with reset during the third compute beat.
    mon_en = 1'b0;
    add_ent(1, 2, 0);
    pulse_start();
    feed_one(0, 0);
    found = 1'b0;
    for (int t = 0; t < 50 && !found; t++) begin
      @(negedge clk_i);
      found = beat_en_o && (buf_raddr_o == 9'd2);
    end
    check_eq("rst_reach_beat2", int'(found), 1);
    rst_ni = 1'b0;
    #1;
    check_quiet("async_rst");
    @(posedge clk_i); #1;
    check_quiet("rst_hold");
    rst_ni = 1'b1;
    e_row.delete(); e_col.delete(); e_last.delete();
    repeat (3) @(posedge clk_i);
    #1;
    mon_en = 1'b1;

    add_ent(1, 2, 0); add_ent(1, 3, 1);
    run_pass(0, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
